// File: rtl/floo_clint_pkg.sv
// Shared types and constants for the CLINT: register map, AXI channel structs, FSM states.
package floo_clint_pkg;

  localparam int unsigned MtimeWidth = 64;
  localparam int unsigned AxiAddrW   = 48;
  localparam int unsigned AxiDataW   = 64;
  localparam int unsigned AxiIdW     = 4;
  localparam int unsigned AxiUserW   = 1;

  localparam logic [15:0] MtimecmpBase = 16'h4000;
  localparam logic [15:0] MtimeOffs    = 16'hBFF8;

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlverr = 2'b10;
  localparam logic [1:0] RespDecerr = 2'b11;

  localparam logic [MtimeWidth-1:0] MtimeRst    = '0;
  localparam logic [MtimeWidth-1:0] MtimecmpRst = '1;

  typedef enum logic [1:0] {IDLE, WDATA, WRESP, RDATA} fsm_e;
  typedef enum logic [1:0] {SelNone, SelMsip, SelMtimecmp, SelMtime} sel_e;

  typedef struct packed {
    logic [AxiIdW-1:0]   id;
    logic [AxiAddrW-1:0] addr;
    logic [7:0]          len;
    logic [2:0]          size;
    logic [1:0]          burst;
    logic [5:0]          atop;
    logic [AxiUserW-1:0] user;
  } axi_aw_t;

  typedef struct packed {
    logic [AxiDataW-1:0]   data;
    logic [AxiDataW/8-1:0] strb;
    logic                  last;
    logic [AxiUserW-1:0]   user;
  } axi_w_t;

  typedef struct packed {
    logic [AxiIdW-1:0]   id;
    logic [1:0]          resp;
    logic [AxiUserW-1:0] user;
  } axi_b_t;

  typedef struct packed {
    logic [AxiIdW-1:0]   id;
    logic [AxiAddrW-1:0] addr;
    logic [7:0]          len;
    logic [2:0]          size;
    logic [1:0]          burst;
    logic [AxiUserW-1:0] user;
  } axi_ar_t;

  typedef struct packed {
    logic [AxiIdW-1:0]   id;
    logic [AxiDataW-1:0] data;
    logic [1:0]          resp;
    logic                last;
    logic [AxiUserW-1:0] user;
  } axi_r_t;

  typedef struct packed {
    axi_aw_t aw;
    logic    aw_valid;
    axi_w_t  w;
    logic    w_valid;
    logic    b_ready;
    axi_ar_t ar;
    logic    ar_valid;
    logic    r_ready;
  } axi_req_t;

  typedef struct packed {
    logic   aw_ready;
    logic   ar_ready;
    logic   w_ready;
    logic   b_valid;
    axi_b_t b;
    logic   r_valid;
    axi_r_t r;
  } axi_rsp_t;

  function automatic logic [63:0] apply_strb(input logic [63:0] old_val,
                                             input logic [63:0] new_val,
                                             input logic [7:0]  strb);
    logic [63:0] res;
    res = old_val;
    for (int b = 0; b < 8; b++) begin
      if (strb[b]) res[8*b +: 8] = new_val[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/floo_clint_timer.sv
// MTIME counter, per-hart MTIMECMP registers and registered timer-interrupt compare.
module floo_clint_timer
  import floo_clint_pkg::*;
#(
  parameter int unsigned NumCores = 9,
  parameter int unsigned IdxW     = 4
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic                                  rtc_tick_i,
  input  logic                                  cmp_we_i,
  input  logic                                  mtime_we_i,
  input  logic [IdxW-1:0]                       idx_i,
  input  logic [63:0]                           wdata_i,
  input  logic [7:0]                            wstrb_i,
  output logic [MtimeWidth-1:0]                 mtime_o,
  output logic [NumCores-1:0][MtimeWidth-1:0]   mtimecmp_o,
  output logic [NumCores-1:0]                   mtip_o
);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mtime_o    <= MtimeRst;
      mtimecmp_o <= {NumCores{MtimecmpRst}};
      mtip_o     <= '0;
    end else begin
      // A bus write to MTIME overrides a coincident tick.
      if (mtime_we_i) mtime_o <= apply_strb(mtime_o, wdata_i, wstrb_i);
      else if (rtc_tick_i) mtime_o <= mtime_o + 64'd1;
      if (cmp_we_i) mtimecmp_o[idx_i] <= apply_strb(mtimecmp_o[idx_i], wdata_i, wstrb_i);
      for (int i = 0; i < NumCores; i++) begin
        mtip_o[i] <= (mtime_o >= mtimecmp_o[i]);
      end
    end
  end

endmodule

// File: rtl/floo_clint_axi.sv
// CLINT behind a single-beat AXI4 subordinate port: per-hart MSIP/MTIMECMP and global MTIME.
//
// state | meaning
// IDLE  | offering AW or AR (never both), alternating on contention
// WDATA | consuming W beats; register written on the last beat when error-free
// WRESP | holding B until b_ready
// RDATA | returning R beats; bursts return zeros with SLVERR
module floo_clint_axi
  import floo_clint_pkg::*;
#(
  parameter int unsigned NumCores     = 9,
  parameter int unsigned AxiAddrWidth = 48,
  parameter int unsigned AxiDataWidth = 64,
  parameter int unsigned AxiIdWidth   = 4,
  parameter type         req_t        = axi_req_t,
  parameter type         rsp_t        = axi_rsp_t
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                rtc_tick_i,
  input  req_t                axi_req_i,
  output rsp_t                axi_rsp_o,
  output logic [NumCores-1:0] msip_o,
  output logic [NumCores-1:0] mtip_o
);

  localparam int unsigned IdxW = (NumCores > 1) ? $clog2(NumCores) : 1;

  if (AxiDataWidth != 64 || AxiAddrWidth != AxiAddrW || AxiIdWidth != AxiIdW) begin : gen_width_err
    $fatal(1, "floo_clint_axi: unsupported AXI widths");
  end

  typedef struct packed {
    sel_e            sel;
    logic [IdxW-1:0] idx;
    logic            hi;
  } dec_t;

  function automatic dec_t decode(input logic [15:0] offs);
    dec_t d;
    logic [15:0] rel;
    d   = '{sel: SelNone, idx: '0, hi: offs[2]};
    rel = offs - MtimecmpBase;
    if (offs == MtimeOffs) begin
      d.sel = SelMtime;
    end else if (offs < MtimecmpBase) begin
      if (offs[1:0] == 2'b00 && 32'(offs >> 2) < NumCores) begin
        d.sel = SelMsip;
        d.idx = IdxW'(offs >> 2);
      end
    end else if (rel[2:0] == 3'b000 && 32'(rel >> 3) < NumCores) begin
      d.sel = SelMtimecmp;
      d.idx = IdxW'(rel >> 3);
    end
    return d;
  endfunction

  fsm_e                                state_q;
  logic                                aw_ready_q, ar_ready_q, w_ready_q;
  logic                                b_valid_q, r_valid_q, last_write_q;
  axi_b_t                              b_q;
  axi_r_t                              r_q;
  logic [7:0]                          beat_cnt_q;
  sel_e                                txn_sel_q;
  logic [IdxW-1:0]                     txn_idx_q;
  logic                                txn_hi_q;
  logic [1:0]                          txn_resp_q;
  logic [NumCores-1:0]                 msip_q;
  logic [MtimeWidth-1:0]               mtime;
  logic [NumCores-1:0][MtimeWidth-1:0] mtimecmp;

  dec_t        aw_dec, ar_dec;
  logic [1:0]  aw_resp, ar_resp;
  logic [63:0] rd_data;
  logic        aw_hs, ar_hs, w_hs, wr_ok, msip_lane, msip_bit;
  logic        unused_req;

  assign unused_req = ^axi_req_i;

  assign aw_hs = (state_q == IDLE) && aw_ready_q && axi_req_i.aw_valid;
  assign ar_hs = (state_q == IDLE) && ar_ready_q && axi_req_i.ar_valid;
  assign w_hs  = (state_q == WDATA) && w_ready_q && axi_req_i.w_valid;
  assign wr_ok = w_hs && axi_req_i.w.last && (txn_resp_q == RespOkay);

  // MSIP is a 32-bit word; its bit 0 sits in the upper lane when addr[2] is set.
  assign msip_lane = txn_hi_q ? axi_req_i.w.strb[4] : axi_req_i.w.strb[0];
  assign msip_bit  = txn_hi_q ? axi_req_i.w.data[32] : axi_req_i.w.data[0];

  always_comb begin
    aw_dec  = decode(axi_req_i.aw.addr[15:0]);
    ar_dec  = decode(axi_req_i.ar.addr[15:0]);
    aw_resp = RespOkay;
    if (axi_req_i.aw.len != 8'd0 || axi_req_i.aw.atop != 6'd0) aw_resp = RespSlverr;
    else if (aw_dec.sel == SelNone) aw_resp = RespDecerr;
    ar_resp = RespOkay;
    if (axi_req_i.ar.len != 8'd0) ar_resp = RespSlverr;
    else if (ar_dec.sel == SelNone) ar_resp = RespDecerr;
    rd_data = '0;
    case (ar_dec.sel)
      SelMsip:     rd_data = ar_dec.hi ? {31'b0, msip_q[ar_dec.idx], 32'b0}
                                       : {63'b0, msip_q[ar_dec.idx]};
      SelMtimecmp: rd_data = mtimecmp[ar_dec.idx];
      SelMtime:    rd_data = mtime;
      default:     rd_data = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      aw_ready_q   <= 1'b0;
      ar_ready_q   <= 1'b0;
      w_ready_q    <= 1'b0;
      b_valid_q    <= 1'b0;
      r_valid_q    <= 1'b0;
      last_write_q <= 1'b0;
      b_q          <= '0;
      r_q          <= '0;
      beat_cnt_q   <= '0;
      txn_sel_q    <= SelNone;
      txn_idx_q    <= '0;
      txn_hi_q     <= 1'b0;
      txn_resp_q   <= RespOkay;
      msip_q       <= '0;
    end else begin
      if (wr_ok && txn_sel_q == SelMsip && msip_lane) msip_q[txn_idx_q] <= msip_bit;
      case (state_q)
        IDLE: begin
          if (aw_hs) begin
            aw_ready_q   <= 1'b0;
            w_ready_q    <= 1'b1;
            last_write_q <= 1'b1;
            b_q.id       <= axi_req_i.aw.id;
            txn_sel_q    <= aw_dec.sel;
            txn_idx_q    <= aw_dec.idx;
            txn_hi_q     <= aw_dec.hi;
            txn_resp_q   <= aw_resp;
            state_q      <= WDATA;
          end else if (ar_hs) begin
            ar_ready_q   <= 1'b0;
            r_valid_q    <= 1'b1;
            last_write_q <= 1'b0;
            beat_cnt_q   <= axi_req_i.ar.len;
            r_q.id       <= axi_req_i.ar.id;
            r_q.resp     <= ar_resp;
            r_q.last     <= (axi_req_i.ar.len == 8'd0);
            r_q.data     <= (ar_resp == RespOkay) ? rd_data : '0;
            state_q      <= RDATA;
          end else begin
            // On contention the channel not served last wins.
            aw_ready_q <= axi_req_i.aw_valid && (!axi_req_i.ar_valid || !last_write_q);
            ar_ready_q <= axi_req_i.ar_valid && (!axi_req_i.aw_valid || last_write_q);
          end
        end
        WDATA: begin
          if (w_hs && axi_req_i.w.last) begin
            w_ready_q <= 1'b0;
            b_valid_q <= 1'b1;
            b_q.resp  <= txn_resp_q;
            state_q   <= WRESP;
          end
        end
        WRESP: begin
          if (axi_req_i.b_ready) begin
            b_valid_q <= 1'b0;
            state_q   <= IDLE;
          end
        end
        RDATA: begin
          if (axi_req_i.r_ready) begin
            if (r_q.last) begin
              r_valid_q <= 1'b0;
              state_q   <= IDLE;
            end else begin
              beat_cnt_q <= beat_cnt_q - 8'd1;
              r_q.last   <= (beat_cnt_q == 8'd1);
              r_q.data   <= '0;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  floo_clint_timer #(
    .NumCores (NumCores),
    .IdxW     (IdxW)
  ) i_timer (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .rtc_tick_i (rtc_tick_i),
    .cmp_we_i   (wr_ok && txn_sel_q == SelMtimecmp),
    .mtime_we_i (wr_ok && txn_sel_q == SelMtime),
    .idx_i      (txn_idx_q),
    .wdata_i    (axi_req_i.w.data),
    .wstrb_i    (axi_req_i.w.strb),
    .mtime_o    (mtime),
    .mtimecmp_o (mtimecmp),
    .mtip_o     (mtip_o)
  );

  assign msip_o = msip_q;

  always_comb begin
    axi_rsp_o          = '0;
    axi_rsp_o.aw_ready = aw_ready_q;
    axi_rsp_o.ar_ready = ar_ready_q;
    axi_rsp_o.w_ready  = w_ready_q;
    axi_rsp_o.b_valid  = b_valid_q;
    axi_rsp_o.b        = b_q;
    axi_rsp_o.r_valid  = r_valid_q;
    axi_rsp_o.r        = r_q;
  end

endmodule

// File: tb/tb_floo_clint_axi.sv
// Scoreboard bench for floo_clint_axi: expected B/R responses queued at issue, checked on handshake.
module tb_floo_clint_axi;
  import floo_clint_pkg::*;

  localparam int unsigned NC = 9;

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic          rst_i, rtc_tick_i;
  axi_req_t      req;
  axi_rsp_t      rsp;
  logic [NC-1:0] msip, mtip;

  axi_aw_t aw_d;
  axi_w_t  w_d;
  axi_ar_t ar_d;
  logic    aw_valid_d, w_valid_d, ar_valid_d, b_ready_d, r_ready_d;

  int n_total = 0;
  int n_bad   = 0;

  typedef struct { logic [1:0] resp; logic [3:0] id; } b_exp_t;
  typedef struct { logic [63:0] data; logic [1:0] resp; logic last; logic [3:0] id; } r_exp_t;
  b_exp_t b_sb[$];
  r_exp_t r_sb[$];
  int     order_q[$];
  b_exp_t be;
  r_exp_t re;

  always_comb begin
    req          = '0;
    req.aw       = aw_d;
    req.aw_valid = aw_valid_d;
    req.w        = w_d;
    req.w_valid  = w_valid_d;
    req.b_ready  = b_ready_d;
    req.ar       = ar_d;
    req.ar_valid = ar_valid_d;
    req.r_ready  = r_ready_d;
  end

  floo_clint_axi #(
    .NumCores     (NC),
    .AxiAddrWidth (48),
    .AxiDataWidth (64),
    .AxiIdWidth   (4),
    .req_t        (axi_req_t),
    .rsp_t        (axi_rsp_t)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .rtc_tick_i (rtc_tick_i),
    .axi_req_i  (req),
    .axi_rsp_o  (rsp),
    .msip_o     (msip),
    .mtip_o     (mtip)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Inputs only change just after posedge, so negedge values are the handshake values.
  always @(negedge clk_i) begin
    if (!rst_i) begin
      if (rsp.aw_ready && aw_valid_d) order_q.push_back(0);
      if (rsp.ar_ready && ar_valid_d) order_q.push_back(1);
      if (rsp.b_valid && b_ready_d) begin
        if (b_sb.size() == 0) chk("b_unexpected", 1, 0);
        else begin
          be = b_sb.pop_front();
          chk("b_resp", 64'(rsp.b.resp), 64'(be.resp));
          chk("b_id", 64'(rsp.b.id), 64'(be.id));
        end
      end
      if (rsp.r_valid && r_ready_d) begin
        if (r_sb.size() == 0) chk("r_unexpected", 1, 0);
        else begin
          re = r_sb.pop_front();
          chk("r_data", rsp.r.data, re.data);
          chk("r_resp", 64'(rsp.r.resp), 64'(re.resp));
          chk("r_last", 64'(rsp.r.last), 64'(re.last));
          chk("r_id", 64'(rsp.r.id), 64'(re.id));
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_write(input logic [15:0] a, input logic [63:0] d, input logic [7:0] s,
                          input logic [7:0] len, input logic [5:0] atop, input logic [3:0] id,
                          input logic [1:0] exp_resp, input logic with_tick);
    int n;
    b_sb.push_back('{resp: exp_resp, id: id});
    aw_d       = '0;
    aw_d.id    = id;
    aw_d.addr  = {32'h0, a};
    aw_d.len   = len;
    aw_d.size  = 3'd3;
    aw_d.burst = 2'd1;
    aw_d.atop  = atop;
    aw_valid_d = 1'b1;
    n = 0;
    while (1) begin
      @(negedge clk_i);
      if (rsp.aw_ready) break;
      if (++n > 50) begin chk("aw_timeout", 1, 0); break; end
    end
    cyc();
    aw_valid_d = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      w_d        = '0;
      w_d.data   = d;
      w_d.strb   = s;
      w_d.last   = (i == int'(len));
      w_valid_d  = 1'b1;
      rtc_tick_i = with_tick;
      n = 0;
      while (1) begin
        @(negedge clk_i);
        if (rsp.w_ready) break;
        if (++n > 50) begin chk("w_timeout", 1, 0); break; end
      end
      cyc();
      w_valid_d  = 1'b0;
      rtc_tick_i = 1'b0;
    end
  endtask

  task automatic do_read(input logic [15:0] a, input logic [7:0] len, input logic [3:0] id,
                         input logic [63:0] exp_data, input logic [1:0] exp_resp);
    int n;
    for (int i = 0; i <= int'(len); i++)
      r_sb.push_back('{data: exp_data, resp: exp_resp, last: (i == int'(len)), id: id});
    ar_d       = '0;
    ar_d.id    = id;
    ar_d.addr  = {32'h0, a};
    ar_d.len   = len;
    ar_d.size  = 3'd3;
    ar_d.burst = 2'd1;
    ar_valid_d = 1'b1;
    n = 0;
    while (1) begin
      @(negedge clk_i);
      if (rsp.ar_ready) break;
      if (++n > 50) begin chk("ar_timeout", 1, 0); break; end
    end
    cyc();
    ar_valid_d = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((b_sb.size() != 0 || r_sb.size() != 0) && n < 200) begin
      cyc();
      n++;
    end
    chk("drain_timeout", 64'(n >= 200), 0);
    cyc();
  endtask

  task automatic reset_dut();
    rst_i = 1'b1;
    repeat (3) cyc();
    rst_i = 1'b0;
    b_sb.delete();
    r_sb.delete();
    order_q.delete();
  endtask

  task automatic rtc_pulses(input int k);
    for (int i = 0; i < k; i++) begin
      rtc_tick_i = 1'b1;
      cyc();
    end
    rtc_tick_i = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_i      = 1'b1;
    rtc_tick_i = 1'b0;
    aw_d = '0; w_d = '0; ar_d = '0;
    aw_valid_d = 1'b0; w_valid_d = 1'b0; ar_valid_d = 1'b0;
    b_ready_d  = 1'b1; r_ready_d = 1'b1;
    cyc();
    reset_dut();

    chk("rst_aw_ready", 64'(rsp.aw_ready), 0);
    chk("rst_ar_ready", 64'(rsp.ar_ready), 0);
    chk("rst_b_valid", 64'(rsp.b_valid), 0);
    chk("rst_r_valid", 64'(rsp.r_valid), 0);
    chk("rst_msip", 64'(msip), 0);
    chk("rst_mtip", 64'(mtip), 0);

    // Arbitration right after reset: write first, then alternate.
    fork
      do_write(16'h4010, 64'h55, 8'hFF, 8'd0, 6'd0, 4'd1, RespOkay, 1'b0);
      do_read(16'h4010, 8'd0, 4'd2, 64'h55, RespOkay);
    join
    wait_idle();
    chk("arb_a_count", 64'(order_q.size()), 2);
    if (order_q.size() >= 2) begin
      chk("arb_a_first", 64'(order_q[0]), 0);
      chk("arb_a_second", 64'(order_q[1]), 1);
    end
    do_write(16'h4010, 64'h77, 8'hFF, 8'd0, 6'd0, 4'd3, RespOkay, 1'b0);
    wait_idle();
    order_q.delete();
    fork
      do_write(16'h4010, 64'h88, 8'hFF, 8'd0, 6'd0, 4'd4, RespOkay, 1'b0);
      do_read(16'h4010, 8'd0, 4'd5, 64'h77, RespOkay);
    join
    wait_idle();
    chk("arb_b_count", 64'(order_q.size()), 2);
    if (order_q.size() >= 2) begin
      chk("arb_b_first", 64'(order_q[0]), 1);
      chk("arb_b_second", 64'(order_q[1]), 0);
    end
    reset_dut();

    // MSIP lanes
    do_write(16'h0008, 64'h1, 8'h0F, 8'd0, 6'd0, 4'd1, RespOkay, 1'b0);
    chk("b_valid_after_w", 64'(rsp.b_valid), 1);
    chk("msip_hart2", 64'(msip), 64'h004);
    wait_idle();
    do_read(16'h0008, 8'd0, 4'd2, 64'h1, RespOkay);
    do_read(16'h000C, 8'd0, 4'd3, 64'h0, RespOkay);
    do_write(16'h000C, 64'h1_0000_0000, 8'hF0, 8'd0, 6'd0, 4'd4, RespOkay, 1'b0);
    wait_idle();
    chk("msip_hart3", 64'(msip), 64'h00C);
    do_read(16'h000C, 8'd0, 4'd5, 64'h1_0000_0000, RespOkay);
    do_read(16'h0024, 8'd0, 4'd6, 64'h0, RespDecerr);
    wait_idle();

    // Timer compare
    do_write(16'h4000, 64'd10, 8'hFF, 8'd0, 6'd0, 4'd7, RespOkay, 1'b0);
    wait_idle();
    rtc_pulses(9);
    cyc();
    chk("mtip_before_10", 64'(mtip), 0);
    rtc_pulses(1);
    chk("mtip_at_10th", 64'(mtip), 0);
    cyc();
    chk("mtip_after_10th", 64'(mtip), 64'h001);
    do_read(16'hBFF8, 8'd0, 4'd8, 64'd10, RespOkay);
    do_write(16'h4000, 64'h20, 8'hFF, 8'd0, 6'd0, 4'd9, RespOkay, 1'b0);
    wait_idle();
    chk("mtip_fall", 64'(mtip), 0);
    do_read(16'h4040, 8'd0, 4'd1, 64'hFFFF_FFFF_FFFF_FFFF, RespOkay);
    do_read(16'h4048, 8'd0, 4'd2, 64'h0, RespDecerr);

    // MTIME wrap, write-vs-tick, byte strobes
    do_write(16'hBFF8, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 8'd0, 6'd0, 4'd3, RespOkay, 1'b0);
    wait_idle();
    rtc_pulses(1);
    do_read(16'hBFF8, 8'd0, 4'd4, 64'h0, RespOkay);
    do_write(16'hBFF8, 64'h1234, 8'hFF, 8'd0, 6'd0, 4'd5, RespOkay, 1'b1);
    wait_idle();
    do_read(16'hBFF8, 8'd0, 4'd6, 64'h1234, RespOkay);
    do_write(16'hBFF8, 64'hAA00, 8'h02, 8'd0, 6'd0, 4'd7, RespOkay, 1'b0);
    wait_idle();
    do_read(16'hBFF8, 8'd0, 4'd8, 64'hAA34, RespOkay);
    wait_idle();

    // Bursts, atomics, unmapped
    do_read(16'hBFF8, 8'd3, 4'd9, 64'h0, RespSlverr);
    do_write(16'h4008, 64'h5, 8'hFF, 8'd1, 6'd0, 4'd10, RespSlverr, 1'b0);
    wait_idle();
    do_read(16'h4008, 8'd0, 4'd11, 64'hFFFF_FFFF_FFFF_FFFF, RespOkay);
    do_write(16'h0000, 64'h1, 8'h0F, 8'd0, 6'h20, 4'd12, RespSlverr, 1'b0);
    wait_idle();
    chk("msip_atop_nochange", 64'(msip), 64'h00C);
    do_read(16'h8000, 8'd0, 4'd13, 64'h0, RespDecerr);
    do_write(16'h8000, 64'h1, 8'hFF, 8'd0, 6'd0, 4'd14, RespDecerr, 1'b0);
    wait_idle();

    // B held under backpressure, then dropped by reset
    b_ready_d = 1'b0;
    do_write(16'h0004, 64'h1, 8'h0F, 8'd0, 6'd0, 4'd15, RespOkay, 1'b0);
    repeat (3) begin
      cyc();
      chk("b_hold_valid", 64'(rsp.b_valid), 1);
      chk("b_hold_id", 64'(rsp.b.id), 64'd15);
    end
    rst_i = 1'b1;
    cyc();
    chk("b_valid_rst", 64'(rsp.b_valid), 0);
    chk("msip_rst", 64'(msip), 0);
    rst_i = 1'b0;
    b_sb.delete();
    b_ready_d = 1'b1;
    cyc();

    wait_idle();
    chk("sb_empty", 64'(b_sb.size() + r_sb.size()), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
